// File: rtl/pixel_timing_gen.sv
// Raster timing generator: walks (h,v) across the full line/frame, decodes
// registered sync/de, line/frame start pulses and a completed-frame counter.
module pixel_timing_gen #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter logic        HSYNC_POL = 1'b0,
   parameter logic        VSYNC_POL = 1'b0,
   parameter int unsigned CW        = 10,
   parameter int unsigned FW        = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          pix_ce,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic [FW-1:0] frame_cnt
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_LO  = CW'(HS_START);
   localparam logic [CW-1:0] HS_HI  = CW'(HS_END);
   localparam logic [CW-1:0] VS_LO  = CW'(VS_START);
   localparam logic [CW-1:0] VS_HI  = CW'(VS_END);

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
       ((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0 ||
       FW < 1) begin : g_param_check
      $error("pixel_timing_gen: invalid timing parameters or counter width");
   end

   logic          h_wrap;
   logic          v_wrap;
   logic [CW-1:0] h_next;
   logic [CW-1:0] v_next;

   // Next raster position for a pixel advance; v only moves on the h wrap.
   always_comb begin
      h_wrap = (x == H_LAST);
      v_wrap = (y == V_LAST);
      h_next = h_wrap ? '0 : x + CW'(1);
      v_next = y;
      if (h_wrap) begin
         v_next = v_wrap ? '0 : y + CW'(1);
      end
   end

   // Position and all decodes are registered from the next position, so
   // x/y and hsync/vsync/de always describe the same pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x           <= '0;
         y           <= '0;
         de          <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else if (!run) begin
         x           <= '0;
         y           <= '0;
         de          <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_ce) begin
         x           <= h_next;
         y           <= v_next;
         de          <= (h_next < H_ACT) && (v_next < V_ACT);
         hsync       <= ((h_next >= HS_LO) && (h_next < HS_HI)) ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= ((v_next >= VS_LO) && (v_next < VS_HI)) ? VSYNC_POL : ~VSYNC_POL;
         line_start  <= h_wrap;
         frame_start <= h_wrap && v_wrap;
         if (h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + FW'(1);
         end
      end else begin
         // Pulses stay one clk wide even when the next pixel is delayed.
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Self-checking bench for pixel_timing_gen on a small 14x7 raster (FW=2),
// compared against a linear pixel-index reference model.
module tb_pixel_timing_gen;

   localparam int HT = 14;
   localparam int VT = 7;
   localparam int FT = HT * VT;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       pix_ce;
   logic       hsync;
   logic       vsync;
   logic       de;
   logic [3:0] x;
   logic [3:0] y;
   logic       line_start;
   logic       frame_start;
   logic [1:0] frame_cnt;

   pixel_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(4), .FW(2)
   ) dut (
      .clk(clk), .rst(rst), .run(run), .pix_ce(pix_ce),
      .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
      .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // reference model: position, idle flag, pulses, frame count
   int mh, mv, mfc;
   bit fresh, mls, mfs;

   int cyc = 0;
   int last_ls = -1;
   int last_fs = -1;
   int exp_lp = 0;
   int exp_fp = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      mh = 0; mv = 0; mfc = 0; fresh = 1; mls = 0; mfs = 0;
   endtask

   task automatic model_step(input bit r, input bit c);
      int p;
      if (rst) begin
         model_reset();
         return;
      end
      mls = 0;
      mfs = 0;
      if (!r) begin
         mh = 0; mv = 0; fresh = 1;
      end else if (c) begin
         p = (mv * HT + mh + 1) % FT;
         mh = p % HT;
         mv = p / HT;
         fresh = 0;
         mls = (mh == 0);
         mfs = (p == 0);
         if (mfs) mfc = (mfc + 1) % 4;
      end
   endtask

   task automatic check_all();
      chk("x", x, mh);
      chk("y", y, mv);
      chk("de", de, !fresh && mh < 8 && mv < 4);
      chk("hsync", hsync, fresh ? 1 : !(mh >= 10 && mh < 12));
      chk("vsync", vsync, fresh ? 1 : !(mv >= 5 && mv < 6));
      chk("line_start", line_start, mls);
      chk("frame_start", frame_start, mfs);
      chk("frame_cnt", frame_cnt, mfc);
   endtask

   task automatic tick(input bit r, input bit c);
      run = r;
      pix_ce = c;
      @(posedge clk);
      model_step(r, c);
      cyc++;
      #1;
      check_all();
      if (line_start === 1'b1) begin
         if (exp_lp != 0 && last_ls >= 0) chk("line_period", cyc - last_ls, exp_lp);
         last_ls = cyc;
      end
      if (frame_start === 1'b1) begin
         if (exp_fp != 0 && last_fs >= 0) chk("frame_period", cyc - last_fs, exp_fp);
         last_fs = cyc;
      end
   endtask

   task automatic goto_pos(input int hx, input int vy);
      for (int i = 0; i < 2 * FT && !(mh == hx && mv == vy && !fresh); i++) tick(1, 1);
      chk("goto_x", x, hx);
      chk("goto_y", y, vy);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int fc_saved;
      int fs_seen;
      logic [1:0] fc_seq[$];
      int exp_seq[5] = '{1, 2, 3, 0, 1};

      // reset state, checked while reset is still asserted
      rst = 1'b1; run = 1'b1; pix_ce = 1'b1;
      model_reset();
      #2;
      check_all();
      tick(1, 1);
      rst = 1'b0;

      // continuous pix_ce: 14-clk lines, 98-clk frames, frame_cnt 0->1->2
      exp_lp = 14; exp_fp = FT; last_ls = -1; last_fs = -1;
      for (int i = 0; i < 2 * FT + 4; i++) tick(1, 1);
      chk("fc_after_two_frames", frame_cnt, 2);

      // pix_ce toggling: lines take 28 clk, pulses remain one clk wide
      exp_lp = 28; exp_fp = 0; last_ls = -1;
      for (int i = 0; i < 6 * HT; i++) tick(1, (i % 2) == 0);
      exp_lp = 0;

      // wrap from (13,6) to (0,0) raises both pulses together
      goto_pos(13, 6);
      tick(1, 1);
      chk("wrap_ls", line_start, 1);
      chk("wrap_fs", frame_start, 1);
      tick(1, 1);
      chk("wrap_ls_clear", line_start, 0);

      // run=0 at (5,2) forces idle; frame_cnt retained; first ce gives x=1
      goto_pos(5, 2);
      fc_saved = mfc;
      tick(0, 1);
      chk("idle_x", x, 0);
      chk("idle_y", y, 0);
      chk("idle_fc", frame_cnt, fc_saved);
      tick(1, 0);
      chk("rerun_hold_x", x, 0);
      tick(1, 1);
      chk("first_ce_x", x, 1);
      chk("first_ce_ls", line_start, 0);

      // asynchronous reset mid-line at (9,3)
      goto_pos(9, 3);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      tick(1, 1);
      rst = 1'b0;
      tick(1, 0);
      tick(1, 1);
      chk("post_rst_x", x, 1);
      chk("post_rst_ls", line_start, 0);

      // randomized run/pix_ce against the model
      for (int i = 0; i < 400; i++) tick($urandom_range(0, 15) != 0, $urandom_range(0, 1) == 1);

      // FW=2 wrap: frame_cnt at each of five frame_starts after reset
      rst = 1'b1;
      tick(1, 1);
      rst = 1'b0;
      fs_seen = 0;
      for (int i = 0; i < 5 * FT + 10 && fs_seen < 5; i++) begin
         tick(1, 1);
         if (frame_start === 1'b1) begin
            fc_seq.push_back(frame_cnt);
            fs_seen++;
         end
      end
      chk("fw_frames_seen", fs_seen, 5);
      for (int i = 0; i < 5; i++) begin
         if (i < fc_seq.size()) chk("fw_seq", fc_seq[i], exp_seq[i]);
         else chk("fw_seq_missing", 32'hFFFF_FFFF, exp_seq[i]);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pixel_timing_gen.md
PIXEL_TIMING_GEN -- requirements
Module: pixel_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter HSYNC_POL, default 0, asserted level of hsync.
REQ-010 SHALL have parameter VSYNC_POL, default 0, asserted level of vsync.
REQ-011 SHALL have parameter CW, default 10, width of the x/y counters.
REQ-012 SHALL have parameter FW, default 8, width of the frame counter.
REQ-013 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-014 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-015 SHALL have port run, input, 1, timing enable; low forces the idle position.
REQ-016 SHALL have port pix_ce, input, 1, pixel clock enable; one pixel advance per clk with pix_ce=1.
REQ-017 SHALL have port hsync, output, 1, horizontal sync at HSYNC_POL when asserted.
REQ-018 SHALL have port vsync, output, 1, vertical sync at VSYNC_POL when asserted.
REQ-019 SHALL have port de, output, 1, display enable.
REQ-020 SHALL have port x, output, CW, current horizontal count.
REQ-021 SHALL have port y, output, CW, current vertical count.
REQ-022 SHALL have port line_start, output, 1, one-clk pulse on entry to h=0.
REQ-023 SHALL have port frame_start, output, 1, one-clk pulse on entry to (h,v)=(0,0).
REQ-024 SHALL have port frame_cnt, output, FW, completed-frame count.

Function
REQ-025 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; all eight timing parameters >=1; CW holds H_TOTAL-1 and V_TOTAL-1 (elaboration-time check).
REQ-026 SHALL advance h by 1 on each clk where run=1 and pix_ce=1; h wraps H_TOTAL-1 -> 0, and only on that wrap v advances by 1, wrapping V_TOTAL-1 -> 0.
REQ-027 SHALL hold h, v and all outputs unchanged on clk edges where run=1 and pix_ce=0.
REQ-028 SHALL drive x=h, y=v as registers with zero latency relative to the counters.
REQ-029 SHALL assert hsync for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, decoded from h only; otherwise drive ~HSYNC_POL.
REQ-030 SHALL assert vsync for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, decoded from v only, across whole lines.
REQ-031 SHALL drive de=1 only when h < H_ACTIVE and v < V_ACTIVE.
REQ-032 SHALL register hsync, vsync, de so they describe the same (h,v) as x,y in the same cycle (no skew).
REQ-033 SHALL pulse line_start high for exactly one clk after a pix_ce edge moves h from H_TOTAL-1 to 0; low otherwise, including while pix_ce=0.
REQ-034 SHALL pulse frame_start in the same cycle as line_start when the wrap also moves v to 0.
REQ-035 SHALL increment frame_cnt modulo 2^FW on each frame_start; run=0 does not clear it.
REQ-036 SHALL, while run=0, synchronously force h=v=0, de=0, syncs deasserted, pulses low; run takes priority over pix_ce.
REQ-037 SHALL, on run 0->1, remain at (0,0) with no pulses until the first pix_ce, which moves h to 1.

Reset
REQ-038 SHALL, while rst=1 and independent of clk, force h=v=0, x=y=0, frame_cnt=0, de=0, line_start=frame_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
REQ-039 SHALL, after rst deassertion mid-frame, restart from (0,0) with no line_start/frame_start pulse for the reset position.

Verification (H 8/2/2/2 total 14, V 4/1/1/1 total 7, POL 0, run=1 unless stated)
REQ-040 SHALL check pix_ce=1 continuous: hsync low for x=10..11, de high x=0..7 on y=0..3, line period 14 clk, frame period 98 clk, frame_cnt 0->1->2.
REQ-041 SHALL check pix_ce toggling 1/0: line period 28 clk, line_start still exactly 1 clk wide, outputs held on ce=0 cycles.
REQ-042 SHALL check wrap (13,6)->(0,0): line_start and frame_start both 1 for one clk, vsync low only for y=5.
REQ-043 SHALL check run=0 at (5,2): next edge x=y=0, de=0, hsync=vsync=1, frame_cnt unchanged; run=1 then first ce gives x=1.
REQ-044 SHALL check rst asserted asynchronously mid-line at (9,3): outputs reach reset values before next clk edge, no pulse after release.
REQ-045 SHALL check FW=2 over 5 frames: frame_cnt sequence 1,2,3,0,1.
